// File: rtl/serial_tx_feeder.sv
// Buffered transmit front-end for quick_rs232: a byte FIFO plus a sequencer that drives
// the tx_transaction / tx_data / tx_data_ready handshake, paced by tx_data_copied and tx_busy.
module serial_tx_feeder #(
  parameter int FIFO_DEPTH          = 16,
  parameter int GAP_CYCLES          = 10,
  parameter int HOLD_CYCLES         = 10,
  parameter int COPY_TIMEOUT_CYCLES = 50000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx_transaction,
  output logic [7:0]                    tx_data,
  output logic                          tx_data_ready,
  input  logic                          tx_data_copied,
  input  logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   sent_count,
  output logic                          timeout_err,
  output logic                          idle
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C   = FIFO_DEPTH[AW:0];
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(COPY_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESENT = 3'd1,
    ST_RELEASE = 3'd2,
    ST_GAP     = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_s;
  logic          pop_s;
  logic [7:0]    head_s;

  state_t        state_q;
  logic [31:0]   cnt_q;
  logic          tx_trans_q;
  logic [7:0]    tx_data_q;
  logic          tx_rdy_q;
  logic [15:0]   sent_q;
  logic          terr_q;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
  assign in_ready = (count_q < DEPTH_C);
  assign push_s   = in_valid && in_ready;
  assign head_s   = mem_q[rd_ptr_q];

  // Pop decision: only in IDLE or at the final HOLD cycle, with data queued and the serializer free.
  always_comb begin
    pop_s = 1'b0;
    if ((count_q != '0) && !tx_busy) begin
      case (state_q)
        ST_IDLE: pop_s = 1'b1;
        ST_HOLD: pop_s = (cnt_q == HOLD_LAST);
        default: pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Handshake sequencer with registered quick_rs232 outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 32'd0;
      tx_trans_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_rdy_q   <= 1'b0;
      sent_q     <= 16'h0000;
      terr_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_trans_q <= 1'b0;
          tx_rdy_q   <= 1'b0;
          if (pop_s) begin
            tx_data_q  <= head_s;
            tx_trans_q <= 1'b1;
            tx_rdy_q   <= 1'b1;
            cnt_q      <= 32'd0;
            state_q    <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (tx_data_copied) begin
            sent_q  <= sent_q + 16'd1;
            state_q <= ST_RELEASE;
          end else if (cnt_q == TO_LAST) begin
            // Abandon the byte: it is not counted and the session moves on.
            terr_q   <= 1'b1;
            tx_rdy_q <= 1'b0;
            cnt_q    <= 32'd0;
            state_q  <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_RELEASE: begin
          if (!tx_data_copied) begin
            cnt_q   <= 32'd0;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            tx_rdy_q <= 1'b0;
            cnt_q    <= 32'd0;
            state_q  <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            // Counter stays saturated while data waits on a busy serializer.
            if (count_q == '0) begin
              tx_trans_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else if (pop_s) begin
              tx_data_q <= head_s;
              tx_rdy_q  <= 1'b1;
              cnt_q     <= 32'd0;
              state_q   <= ST_PRESENT;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          tx_trans_q <= 1'b0;
          tx_rdy_q   <= 1'b0;
          cnt_q      <= 32'd0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_transaction = tx_trans_q;
  assign tx_data        = tx_data_q;
  assign tx_data_ready  = tx_rdy_q;
  assign fifo_count     = count_q;
  assign sent_count     = sent_q;
  assign timeout_err    = terr_q;
  assign idle           = (state_q == ST_IDLE) && (count_q == '0);

endmodule

// File: tb/tb_serial_tx_feeder.sv
// Randomised bench for serial_tx_feeder: a queue model of the FIFO plus a quick_rs232 sink
// model; handshake timing is derived from the GAP/HOLD/timeout rules as plain arithmetic.
`timescale 1ns/1ps
module tb_serial_tx_feeder;
  localparam int DEPTH = 16;
  localparam int GAP   = 10;
  localparam int HOLD  = 10;
  localparam int TO    = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        tx_transaction;
  logic [7:0]  tx_data;
  logic        tx_data_ready;
  logic        tx_data_copied = 1'b0;
  logic        tx_busy = 1'b0;
  logic [4:0]  fifo_count;
  logic [15:0] sent_count;
  logic        timeout_err;
  logic        idle;

  int tests = 0;
  int fails = 0;

  logic [7:0] model_q[$];
  logic [7:0] cur_byte = 8'h00;
  bit prev_ready = 1'b0, prev_trans = 1'b0, acked = 1'b1, in_low = 1'b0;
  bit timing_en = 1'b1, rand_sink = 1'b0, sink_never = 1'b0;
  int age = 0, cw = 0, hi_len = 0, lo_len = 0, cur_d = 0, cur_w = 1;
  int fix_d = 3, fix_w = 2, exp_sent = 0, falls = 0, drops = 0, rises = 0;

  serial_tx_feeder #(
    .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD), .COPY_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_transaction(tx_transaction), .tx_data(tx_data), .tx_data_ready(tx_data_ready),
    .tx_data_copied(tx_data_copied), .tx_busy(tx_busy), .fifo_count(fifo_count),
    .sent_count(sent_count), .timeout_err(timeout_err), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_bench();
    model_q.delete();
    prev_ready = 1'b0;
    prev_trans = 1'b0;
    in_low = 1'b0;
    acked = 1'b1;
    tx_data_copied = 1'b0;
    exp_sent = 0;
  endtask

  // One clock: apply inputs, update the model, check outputs, then drive the sink for the next cycle.
  task automatic step();
    bit do_push;
    logic [7:0] pd;
    bit rise, fall;
    do_push = in_valid && in_ready && !rst;
    pd = in_data;
    @(posedge clk);
    #1;
    if (do_push) model_q.push_back(pd);
    rise = tx_data_ready && !prev_ready;
    fall = !tx_data_ready && prev_ready;
    if (fall) begin
      falls++;
      check_eq("ready_high_len", 32'(hi_len), acked ? 32'(cur_d + 1 + cur_w + GAP) : 32'(TO));
      in_low = 1'b1;
      lo_len = 0;
    end else if (in_low) begin
      lo_len++;
    end
    if (rise) begin
      rises++;
      if (in_low && timing_en) check_eq("hold_gap", 32'(lo_len), 32'(HOLD));
      in_low = 1'b0;
      check_eq("present_has_byte", 32'(model_q.size() != 0), 32'd1);
      if (model_q.size() != 0) begin
        cur_byte = model_q.pop_front();
        check_eq("present_order", {24'd0, tx_data}, {24'd0, cur_byte});
      end
      hi_len = 0;
      age = 0;
      acked = 1'b0;
      cur_d = rand_sink ? int'($urandom_range(0, 4)) : fix_d;
      cur_w = rand_sink ? int'($urandom_range(1, 3)) : fix_w;
    end else if (tx_data_ready) begin
      age++;
    end
    if (tx_data_ready) begin
      hi_len++;
      check_eq("data_stable", {24'd0, tx_data}, {24'd0, cur_byte});
    end
    if (prev_trans && !tx_transaction) begin
      drops++;
      if (in_low && timing_en) check_eq("close_delay", 32'(lo_len), 32'(HOLD));
      in_low = 1'b0;
    end
    check_eq("fifo_count", {27'd0, fifo_count}, 32'(model_q.size()));
    check_eq("in_ready", {31'd0, in_ready}, 32'(model_q.size() < DEPTH));
    if (tx_data_ready && !acked && !sink_never && age == cur_d) begin
      tx_data_copied = 1'b1;
      acked = 1'b1;
      exp_sent++;
      cw = 0;
    end else if (tx_data_copied) begin
      cw++;
      if (cw >= cur_w) tx_data_copied = 1'b0;
    end
    prev_ready = tx_data_ready;
    prev_trans = tx_transaction;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = !tx_transaction && !tx_data_ready && !tx_data_copied && (model_q.size() == 0);
    end
    check_eq("drain_done", {31'd0, done}, 32'd1);
    check_eq("idle_after_drain", {31'd0, idle}, 32'd1);
    check_eq("sent_count", {16'd0, sent_count}, exp_sent[31:0] & 32'h0000_FFFF);
  endtask

  initial begin
    int idx, drops0, rises0, target;
    bit acc;

    // Reset with in_valid held high: nothing may be pushed.
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_trans", {31'd0, tx_transaction}, 32'd0);
    check_eq("rst_ready", {31'd0, tx_data_ready}, 32'd0);
    check_eq("rst_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst_count", {27'd0, fifo_count}, 32'd0);
    check_eq("rst_sent", {16'd0, sent_count}, 32'd0);
    check_eq("rst_terr", {31'd0, timeout_err}, 32'd0);
    check_eq("rst_idle", {31'd0, idle}, 32'd1);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    in_valid = 1'b0;
    reset_bench();
    step();

    // First byte latency: pushed at edge N, presented after edge N+1.
    push_byte(8'h41);
    check_eq("lat_not_yet", {31'd0, tx_data_ready}, 32'd0);
    step();
    check_eq("lat_ready", {31'd0, tx_data_ready}, 32'd1);
    check_eq("lat_data", {24'd0, tx_data}, 32'h41);
    check_eq("lat_trans", {31'd0, tx_transaction}, 32'd1);
    drain(200);

    // Single byte with fixed sink timing.
    push_byte(8'h55);
    drain(200);

    // Burst of 20 with the serializer busy until the FIFO fills.
    drops0 = drops;
    tx_busy = 1'b1;
    fix_d = 1;
    fix_w = 1;
    idx = 0;
    for (int cyc = 0; cyc < 3000 && idx < 20; cyc++) begin
      in_valid = 1'b1;
      in_data = 8'(idx);
      acc = in_ready;
      step();
      if (acc) idx++;
      if (idx == 16 && tx_busy) begin
        in_data = 8'(idx);
        repeat (3) step();
        check_eq("full_count", {27'd0, fifo_count}, 32'd16);
        check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
        tx_busy = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("burst_pushed", 32'(idx), 32'd20);
    drain(3000);
    check_eq("burst_one_session", 32'(drops - drops0), 32'd1);

    // Sink never copies: both bytes time out and are not counted.
    sink_never = 1'b1;
    rises0 = rises;
    push_byte(8'hC3);
    push_byte(8'h3C);
    drain(1000);
    check_eq("timeout_err", {31'd0, timeout_err}, 32'd1);
    check_eq("timeout_presented", 32'(rises - rises0), 32'd2);
    sink_never = 1'b0;

    // tx_busy held over the end of HOLD stalls the next pop.
    fix_d = 2;
    fix_w = 1;
    timing_en = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    target = falls + 1;
    for (int i = 0; i < 200 && falls < target; i++) step();
    check_eq("busy_first_done", 32'(falls), 32'(target));
    tx_busy = 1'b1;
    repeat (HOLD + 5) step();
    check_eq("busy_no_pop", {31'd0, tx_data_ready}, 32'd0);
    check_eq("busy_session_open", {31'd0, tx_transaction}, 32'd1);
    tx_busy = 1'b0;
    step();
    check_eq("busy_release_pop", {31'd0, tx_data_ready}, 32'd1);
    check_eq("busy_release_data", {24'd0, tx_data}, 32'h22);
    timing_en = 1'b1;
    drain(300);

    // Random traffic with random sink timing.
    rand_sink = 1'b1;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    drain(6000);
    rand_sink = 1'b0;

    // Asynchronous reset in the middle of GAP with bytes still queued.
    fix_d = 1;
    fix_w = 1;
    for (int i = 0; i < 6; i++) push_byte(8'hE0 + 8'(i));
    for (int i = 0; i < 100 && !(acked && !tx_data_copied); i++) step();
    check_eq("gap_reached", {31'd0, acked && !tx_data_copied}, 32'd1);
    repeat (4) step();
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_ready", {31'd0, tx_data_ready}, 32'd0);
    check_eq("arst_trans", {31'd0, tx_transaction}, 32'd0);
    check_eq("arst_count", {27'd0, fifo_count}, 32'd0);
    check_eq("arst_data", {24'd0, tx_data}, 32'd0);
    check_eq("arst_sent", {16'd0, sent_count}, 32'd0);
    check_eq("arst_terr", {31'd0, timeout_err}, 32'd0);
    check_eq("arst_idle", {31'd0, idle}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_bench();
    rises0 = rises;
    repeat (50) step();
    check_eq("no_stale_present", 32'(rises - rises0), 32'd0);
    check_eq("post_rst_idle", {31'd0, idle}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
